// File: rtl/io_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_pkg : op_io encodings and sequencer state type                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package io_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_IN   = 2'b01;
  localparam logic [1:0] OP_OUT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_IN_WAIT    = 3'd1,
    S_IN_PRESS   = 3'd2,
    S_IN_RELEASE = 3'd3,
    S_IN_COMMIT  = 3'd4,
    S_OUT_DRIVE  = 3'd5,
    S_OUT_DONE   = 3'd6
  } io_state_t;

  function automatic logic [1:0] op_of_state(input io_state_t s);
    case (s)
      S_IN_WAIT, S_IN_PRESS, S_IN_RELEASE: op_of_state = OP_IN;
      S_OUT_DRIVE:                         op_of_state = OP_OUT;
      default:                             op_of_state = OP_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_sequencer_sync_2ff.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_2ff : two-flop synchroniser with configurable reset value   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/io_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_sequencer : drives op_io for IN/OUT, stalls, commits IN data  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module io_sequencer
  import io_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OUT_HOLD        = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_in_req,
  input  logic                      i_out_req,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_out_data,
  input  logic [DATA_WIDTH-1:0]     i_sio,
  input  logic                      i_wait_flag,
  output logic [1:0]                o_op_io,
  output logic [DATA_WIDTH-1:0]     o_data_disp,
  output logic                      o_stall,
  output logic                      o_rf_we,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0]     o_rf_wdata,
  output logic                      o_proto_err
);

  localparam int C_CNT_MAX = (DEBOUNCE_CYCLES > OUT_HOLD) ? DEBOUNCE_CYCLES : OUT_HOLD;
  localparam int C_CW      = $clog2(C_CNT_MAX + 1);
  localparam logic [C_CW-1:0] C_ONE = C_CW'(1);
  localparam logic [C_CW-1:0] C_DB  = C_CW'(DEBOUNCE_CYCLES);
  localparam logic [C_CW-1:0] C_OH  = C_CW'(OUT_HOLD);

  io_state_t                 r_state, w_next;
  logic [C_CW-1:0]           r_cnt, w_cnt_next, w_cnt_inc;
  logic [1:0]                r_op_io;
  logic [REG_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_data, r_disp;
  logic                      r_proto_err;
  logic                      w_wait_s, w_capture, w_accept_in, w_accept_out;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_wait_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_wait_flag),
    .o_sync  (w_wait_s)
  );

  assign w_cnt_inc = r_cnt + C_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op_io     <= OP_NONE;
      r_addr      <= '0;
      r_data      <= '0;
      r_disp      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      // op_io is registered from the next state so it tracks the state with no glitches
      r_op_io     <= op_of_state(w_next);
      r_proto_err <= (r_state == S_IDLE) && i_in_req && i_out_req;
      if (w_accept_in)  r_addr <= i_rd_addr;
      if (w_accept_out) r_disp <= i_out_data;
      if (w_capture)    r_data <= i_sio;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_accept_in  = 1'b0;
    w_accept_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (i_in_req) begin
          w_next      = S_IN_WAIT;
          w_accept_in = 1'b1;
        end else if (i_out_req) begin
          w_next       = S_OUT_DRIVE;
          w_accept_out = 1'b1;
        end
      end
      S_IN_WAIT: begin
        w_cnt_next = '0;
        if (!w_wait_s) begin
          if (C_DB == C_ONE) begin
            w_next    = S_IN_RELEASE;
            w_capture = 1'b1;
          end else begin
            w_next     = S_IN_PRESS;
            w_cnt_next = C_ONE;
          end
        end
      end
      S_IN_PRESS: begin
        if (w_wait_s) begin
          w_next     = S_IN_WAIT;
          w_cnt_next = '0;
        end else if (w_cnt_inc == C_DB) begin
          w_next     = S_IN_RELEASE;
          w_cnt_next = '0;
          w_capture  = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_IN_RELEASE: begin
        if (!w_wait_s) begin
          w_cnt_next = '0;
        end else if (w_cnt_inc == C_DB) begin
          w_next     = S_IN_COMMIT;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_IN_COMMIT: w_next = S_IDLE;
      S_OUT_DRIVE: begin
        if (w_cnt_inc == C_OH) begin
          w_next     = S_OUT_DONE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_OUT_DONE: w_next = S_IDLE;
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  // Stall covers the decode cycle too, so the pipeline freezes before the FSM leaves IDLE
  always_comb begin
    o_stall = 1'b0;
    o_rf_we = 1'b0;
    case (r_state)
      S_IDLE:                                           o_stall = i_in_req | i_out_req;
      S_IN_WAIT, S_IN_PRESS, S_IN_RELEASE, S_OUT_DRIVE: o_stall = 1'b1;
      S_IN_COMMIT:                                      o_rf_we = 1'b1;
      default:                                          o_stall = 1'b0;
    endcase
  end

  assign o_op_io     = r_op_io;
  assign o_data_disp = r_disp;
  assign o_rf_waddr  = r_addr;
  assign o_rf_wdata  = r_data;
  assign o_proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_io_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_io_sequencer : directed self-checking bench for io_sequencer  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_io_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_req, out_req, wait_flag;
  logic [4:0]  rd_addr;
  logic [31:0] out_data, sio;
  logic [1:0]  op_io;
  logic [31:0] data_disp, rf_wdata;
  logic        stall, rf_we, proto_err;
  logic [4:0]  rf_waddr;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;
  int base, lat;
  logic [1:0] exp_op    [5];
  logic       exp_stall [5];

  always #5 clk = ~clk;

  io_sequencer #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .DEBOUNCE_CYCLES(4), .OUT_HOLD(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_req    (in_req),
    .i_out_req   (out_req),
    .i_rd_addr   (rd_addr),
    .i_out_data  (out_data),
    .i_sio       (sio),
    .i_wait_flag (wait_flag),
    .o_op_io     (op_io),
    .o_data_disp (data_disp),
    .o_stall     (stall),
    .o_rf_we     (rf_we),
    .o_rf_waddr  (rf_waddr),
    .o_rf_wdata  (rf_wdata),
    .o_proto_err (proto_err)
  );

  always @(negedge clk) if (rf_we === 1'b1) we_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_we(input string tag, output int k_out);
    k_out = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (rf_we === 1'b1) begin
        k_out = k;
        break;
      end
    end
    check(tag, {31'd0, rf_we}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_req = 1'b0; out_req = 1'b0; wait_flag = 1'b1;
    rd_addr = '0; out_data = '0; sio = '0;
    exp_op    = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    exp_stall = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    step(2);

    // reset state; stall is combinational on the requests even in reset
    in_req = 1'b1; #1;
    check("rst_stall_req", {31'd0, stall}, 32'd1);
    check("rst_op", {30'd0, op_io}, 32'd0);
    check("rst_disp", data_disp, 32'd0);
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_perr", {31'd0, proto_err}, 32'd0);
    in_req = 1'b0; #1;
    check("rst_stall_idle", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    step(2);
    check("idle_op", {30'd0, op_io}, 32'd0);
    check("idle_stall", {31'd0, stall}, 32'd0);

    // OUT 0x1234: op 10 for two cycles, stall for three
    out_req = 1'b1; out_data = 32'h1234; #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("out_op_c%0d", k), {30'd0, op_io}, {30'd0, exp_op[k]});
      check($sformatf("out_stall_c%0d", k), {31'd0, stall}, {31'd0, exp_stall[k]});
      if (k == 3) out_req = 1'b0;
      step(1);
    end
    check("out_disp", data_disp, 32'h1234);
    out_data = 32'hFFFF;
    step(3);
    check("out_disp_held", data_disp, 32'h1234);

    // clean IN: rd 7, switches 0x2A5, commit only after release
    base = we_cnt;
    rd_addr = 5'd7; sio = 32'h2A5; in_req = 1'b1;
    step(1);
    check("in_wait_op", {30'd0, op_io}, 32'd1);
    check("in_wait_stall", {31'd0, stall}, 32'd1);
    step(3);
    wait_flag = 1'b0;
    step(10);
    check("in_held_no_we", we_cnt, base);
    check("in_held_op", {30'd0, op_io}, 32'd1);
    sio = 32'h3FF;
    wait_flag = 1'b1;
    wait_we("in_we_seen", lat);
    check("in_release_lat", lat, 32'd6);
    check("in_waddr", {27'd0, rf_waddr}, 32'd7);
    check("in_wdata", rf_wdata, 32'h2A5);
    check("in_commit_op", {30'd0, op_io}, 32'd0);
    check("in_commit_stall", {31'd0, stall}, 32'd0);
    in_req = 1'b0;
    step(1);
    check("in_we_single", {31'd0, rf_we}, 32'd0);
    check("in_we_count", we_cnt, base + 1);

    // bouncing press: 2 low, 1 high, then 10 low
    base = we_cnt;
    rd_addr = 5'd3; sio = 32'h11; in_req = 1'b1;
    step(1);
    wait_flag = 1'b0;
    step(2);
    wait_flag = 1'b1;
    step(1);
    wait_flag = 1'b0; sio = 32'h55;
    check("bounce_op", {30'd0, op_io}, 32'd1);
    step(10);
    check("bounce_no_we", we_cnt, base);
    wait_flag = 1'b1;
    wait_we("bounce_we_seen", lat);
    check("bounce_waddr", {27'd0, rf_waddr}, 32'd3);
    check("bounce_wdata", rf_wdata, 32'h55);
    in_req = 1'b0;
    step(1);
    check("bounce_we_count", we_cnt, base + 1);

    // back-to-back INs: long press satisfies only the first
    base = we_cnt;
    rd_addr = 5'd1; sio = 32'hA; in_req = 1'b1;
    step(1);
    wait_flag = 1'b0;
    step(15);
    check("b2b_hold_no_we", we_cnt, base);
    check("b2b_hold_stall", {31'd0, stall}, 32'd1);
    wait_flag = 1'b1;
    wait_we("b2b_we1_seen", lat);
    check("b2b_waddr1", {27'd0, rf_waddr}, 32'd1);
    check("b2b_wdata1", rf_wdata, 32'hA);
    rd_addr = 5'd2; sio = 32'hB;
    step(1);
    check("b2b_idle_stall", {31'd0, stall}, 32'd1);
    check("b2b_idle_op", {30'd0, op_io}, 32'd0);
    step(11);
    check("b2b_second_waits", we_cnt, base + 1);
    check("b2b_second_op", {30'd0, op_io}, 32'd1);
    wait_flag = 1'b0;
    step(8);
    wait_flag = 1'b1;
    wait_we("b2b_we2_seen", lat);
    check("b2b_waddr2", {27'd0, rf_waddr}, 32'd2);
    check("b2b_wdata2", rf_wdata, 32'hB);
    in_req = 1'b0;
    step(1);

    // both requests: IN wins with one proto_err pulse, then reset during release
    rd_addr = 5'd9; out_data = 32'hBEEF; sio = 32'h77;
    in_req = 1'b1; out_req = 1'b1; #1;
    check("perr_stall", {31'd0, stall}, 32'd1);
    check("perr_before", {31'd0, proto_err}, 32'd0);
    step(1);
    out_req = 1'b0;
    check("perr_pulse", {31'd0, proto_err}, 32'd1);
    check("perr_in_op", {30'd0, op_io}, 32'd1);
    step(1);
    check("perr_one_cycle", {31'd0, proto_err}, 32'd0);
    check("perr_disp_kept", data_disp, 32'h1234);
    wait_flag = 1'b0;
    step(8);
    wait_flag = 1'b1;
    step(2);
    check("rel_op", {30'd0, op_io}, 32'd1);
    base = we_cnt;
    in_req = 1'b0;
    rst_n = 1'b0; #1;
    check("abort_op", {30'd0, op_io}, 32'd0);
    check("abort_disp", data_disp, 32'd0);
    check("abort_we", {31'd0, rf_we}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(10);
    check("abort_no_we", we_cnt, base);
    check("abort_idle_op", {30'd0, op_io}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_sequencer.md
# io_sequencer

CPU-side controller for the board I/O unit: turns decoded IN/OUT instructions into the `op_io` protocol, stalls the pipeline until the transfer completes, and commits IN data to the register file. It synchronises and debounces the I/O unit's `wait_flag`. After each IN it requires the confirm button to be released, so one press satisfies exactly one IN. It sits between the control unit/register file and the switch/7-segment I/O unit.

## Interface
- `DATA_WIDTH`, 32, datapath width
- `REG_ADDR_WIDTH`, 5, register-file address width
- `DEBOUNCE_CYCLES`, 4, consecutive synchronised cycles required to accept a press or a release (≥1)
- `OUT_HOLD`, 2, cycles `op_io`=OUT is driven per OUT (≥1)

- `clk` in 1: single clock, all flops rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `in_req` in 1: current instruction is IN
- `out_req` in 1: current instruction is OUT
- `rd_addr` in REG_ADDR_WIDTH: IN destination register
- `out_data` in DATA_WIDTH: OUT value
- `sio` in DATA_WIDTH: input data from the I/O unit (switches, zero-extended)
- `wait_flag` in 1: I/O unit waiting for a press (asynchronous, combinational from the button)
- `op_io` out 2: 00 none, 01 IN, 10 OUT; registered
- `data_disp` out DATA_WIDTH: value to display; registered
- `stall` out 1: hold PC/pipeline
- `rf_we` out 1: register-file write strobe, one cycle
- `rf_waddr` out REG_ADDR_WIDTH: write address
- `rf_wdata` out DATA_WIDTH: write data
- `proto_err` out 1: one-cycle pulse when `in_req` and `out_req` are sampled together in IDLE

## Operation
- `wait_flag` passes through a 2-flop synchroniser, producing `wait_s`. Both flops reset to 1.
- States and their outputs:
  - IDLE: `op_io`=00.
    - `in_req` → IN_WAIT. Latch `rd_addr`.
    - `out_req` (and no `in_req`) → OUT_DRIVE. Latch `out_data` into `data_disp`.
    - Both requests high: IN wins, and `proto_err` pulses.
  - IN_WAIT: `op_io`=01, counter=0.
    - `wait_s`=0 → IN_PRESS, counter=1.
  - IN_PRESS:
    - `wait_s`=0: counter increments.
    - Counter reaches DEBOUNCE_CYCLES: capture `sio` into the data register and go to IN_RELEASE with counter=0.
    - `wait_s`=1 before that: go back to IN_WAIT (bounce).
  - IN_RELEASE: `op_io` stays 01.
    - Requires DEBOUNCE_CYCLES consecutive cycles of `wait_s`=1. Any 0 resets the counter.
    - Then → IN_COMMIT.
  - IN_COMMIT: `op_io`=00, `rf_we`=1, `rf_waddr`=latched address, `rf_wdata`=captured value → IDLE.
  - OUT_DRIVE: `op_io`=10 for exactly OUT_HOLD cycles (counter), then → OUT_DONE.
  - OUT_DONE: `op_io`=00 → IDLE. `data_disp` keeps its value until the next OUT.
- `stall` is combinational:
  - 1 in IDLE when `in_req` or `out_req` is high (same cycle as decode).
  - 1 in IN_WAIT, IN_PRESS, IN_RELEASE and OUT_DRIVE.
  - 0 in IN_COMMIT, OUT_DONE and idle IDLE.
- Requests are ignored in IN_COMMIT and OUT_DONE, because the retiring instruction is still presented. A new request is accepted in the following IDLE cycle.
- The captured value is the `sio` value sampled on the debounce-complete edge. Later `sio` changes do not alter `rf_wdata`.
- Counter width is clog2(max(DEBOUNCE_CYCLES, OUT_HOLD)+1).

## Timing
- Reset values: state IDLE, `op_io`=00, `data_disp`=0, `stall`=`in_req`|`out_req`, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `proto_err`=0, synchroniser flops 1.
- An async reset mid-transfer aborts with no register-file write. The display value returns to 0.
- OUT: request in cycle 0. `op_io`=10 in cycles 1..OUT_HOLD, OUT_DONE in cycle OUT_HOLD+1. `stall` is high for cycles 0..OUT_HOLD.
- IN, with `wait_flag` falling while in IN_WAIT:
  - `wait_s` follows 2 cycles later.
  - Capture happens DEBOUNCE_CYCLES cycles after that.
  - Release takes at least DEBOUNCE_CYCLES + 2 further cycles.
  - Then one commit cycle.
- `rf_we` is never high for more than one cycle per IN.
- `op_io` changes only on clock edges.

## Structure
- Shared package `io_pkg`:
  - `op_io` encodings `OP_NONE`=2'b00, `OP_IN`=2'b01, `OP_OUT`=2'b10
  - state enum `io_state_t`
- Sub-module `sync_2ff`: a parameterised-reset-value 2-flop synchroniser, reused for other asynchronous board inputs.

## Test plan
- Reset, then idle: `op_io`=00, `data_disp`=0, `stall`=0, `rf_we`=0.
- OUT with `out_data`=0x1234, OUT_HOLD=2 → `op_io`=10 for exactly 2 cycles, `data_disp`=0x1234 held afterwards, `stall` high for 3 cycles.
- IN with `rd_addr`=7, switches 0x2A5, clean press then release → a single `rf_we` pulse with `rf_waddr`=7 and `rf_wdata`=0x0000_02A5, issued only after release.
- Bouncing press (`wait_flag` low 2 cycles, high, then low 10 cycles) → no capture on the bounce; capture once on the stable press.
- Two back-to-back INs with a single long press → the first commits only after release; the second waits for a new press.
- `in_req`=`out_req`=1 → `proto_err` one cycle, IN performed. `rst_n` low in IN_RELEASE → immediate IDLE, no `rf_we`.
